vector_sequencer: RTL and testbench

//  Parametrised, synthesisable, self-checking stimulus/response engine for DUT bring-up.

---
 rtl/vector_sequencer_pkg.sv | 30 +++
 rtl/vector_sequencer_if.sv | 31 +++
 rtl/vseq_delay_line.sv | 31 +++
 rtl/vector_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vector_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_sequencer_pkg.sv
// Shared types and helpers for the vector sequencer.
// Lane compare helper works on a widened bus so any lane geometry fits.
package vector_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int MAX_CH  = 16;
    localparam int MAX_BUS = 128;

    function automatic logic [MAX_CH-1:0] lane_mismatch(
        input logic [MAX_BUS-1:0] a,
        input logic [MAX_BUS-1:0] b,
        input int unsigned        dw
    );
        logic [MAX_CH-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_BUS; k++) begin
            if (a[k] != b[k]) begin
                m = m | (MAX_CH'(1) << (k / dw));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Loader and DUT-facing bus of the vector sequencer.
// master = sequencer side, slave = host loader / DUT side.
interface vector_sequencer_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16
);
    localparam int BW = CHANNELS * DATA_W;
    localparam int AW = $clog2(DEPTH);

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [BW-1:0] load_stim;
    logic [BW-1:0] load_exp;
    logic          stim_valid;
    logic [BW-1:0] stim_data;
    logic [BW-1:0] dut_data;

    modport master (
        input  load_en, load_addr, load_stim, load_exp,
        output stim_valid, stim_data,
        input  dut_data
    );

    modport slave (
        output load_en, load_addr, load_stim, load_exp,
        input  stim_valid, stim_data,
        output dut_data
    );

endinterface

// File: rtl/vseq_delay_line.sv
// Async-reset shift register carrying {valid, idx} alongside the DUT.
// Output appears LATENCY cycles after the input.
module vseq_delay_line #(
    parameter int W       = 5,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [LATENCY];

    // shift one stage per cycle, cleared on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < LATENCY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[LATENCY-1];

endmodule

// File: rtl/vector_sequencer.sv
// Stimulus replay and response checking engine for DUT bring-up.
// Issues preloaded vectors one per cycle and compares DUT output after LATENCY.
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  CHANNELS = 2,
    parameter int  DEPTH    = 16,
    parameter int  LATENCY  = 2,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = CHANNELS * DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_sequencer_if.master    bus,
    input  logic [AW:0]           num_vec,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [AW:0]           err_count,
    output logic [CHANNELS-1:0]   err_lane_mask,
    output logic [AW-1:0]         first_err_idx
);

    localparam int CW = $clog2(LATENCY + 1) + 1;

    state_t            state;
    state_t            state_nx;
    logic [AW:0]       rd_idx;
    logic [AW:0]       num_q;
    logic [CW-1:0]     drain_cnt;
    logic              aborted;
    logic              issue;
    logic              num_ok;
    logic [BW-1:0]     stim_mem [DEPTH];
    logic [BW-1:0]     exp_mem  [DEPTH];
    logic [BW-1:0]     exp_q;
    logic              dl_valid;
    logic [AW-1:0]     dl_idx;
    logic              cmp_valid;
    logic [AW-1:0]     cmp_idx;
    logic [MAX_CH-1:0] mm_all;
    logic [CHANNELS-1:0] mm;
    logic              hit;
    logic              unused_mm;

    assign busy   = (state == RUN) || (state == DRAIN);
    assign num_ok = (num_vec != '0) && (num_vec <= (AW+1)'(DEPTH));

    // next-state decode; a run ends after the last issue or on abort
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = num_ok ? RUN : DONE;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (abort || (rd_idx == num_q - (AW+1)'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == CW'(LATENCY)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // vector RAMs: writes blocked during a run, expect read one cycle ahead of compare
    always_ff @(posedge clk) begin
        if (bus.load_en && !busy) begin
            stim_mem[bus.load_addr] <= bus.load_stim;
            exp_mem[bus.load_addr]  <= bus.load_exp;
        end
        exp_q <= exp_mem[dl_idx];
    end

    // issue side: registered stimulus, read index and run length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.stim_valid <= 1'b0;
            bus.stim_data  <= '0;
            rd_idx         <= '0;
            num_q          <= '0;
            drain_cnt      <= '0;
        end else begin
            bus.stim_valid <= issue;
            if (issue) begin
                bus.stim_data <= stim_mem[rd_idx[AW-1:0]];
                rd_idx        <= rd_idx + (AW+1)'(1);
            end
            if (state == IDLE && start) begin
                rd_idx <= '0;
                num_q  <= num_vec;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + CW'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    vseq_delay_line #(
        .W       (AW + 1),
        .LATENCY (LATENCY)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   ({issue, rd_idx[AW-1:0]}),
        .q   ({dl_valid, dl_idx})
    );

    // final stage lines up with exp_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_valid <= 1'b0;
            cmp_idx   <= '0;
        end else begin
            cmp_valid <= dl_valid;
            cmp_idx   <= dl_idx;
        end
    end

    assign mm_all = lane_mismatch(MAX_BUS'(bus.dut_data), MAX_BUS'(exp_q), DATA_W);
    assign mm        = mm_all[CHANNELS-1:0];
    assign unused_mm = ^mm_all[MAX_CH-1:CHANNELS];
    assign hit       = cmp_valid && (|mm);

    // result tracking; pass folds in a mismatch landing on the final drain cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            aborted       <= 1'b0;
            err_count     <= '0;
            err_lane_mask <= '0;
            first_err_idx <= '0;
        end else begin
            done <= (state_nx == DONE);
            if (state == IDLE && start) begin
                pass          <= 1'b0;
                aborted       <= 1'b0;
                err_count     <= '0;
                err_lane_mask <= '0;
                first_err_idx <= '0;
            end else if (hit) begin
                if (err_count != (AW+1)'(DEPTH)) begin
                    err_count <= err_count + (AW+1)'(1);
                end
                err_lane_mask <= err_lane_mask | mm;
                if (err_count == '0) begin
                    first_err_idx <= cmp_idx;
                end
            end
            if (state == RUN && abort) begin
                aborted <= 1'b1;
            end
            if (state == DRAIN && state_nx == DONE) begin
                pass <= !aborted && (err_count == '0) && !hit;
            end
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with an identity DUT of latency 2.
// Expected results come from a vector-level model of each run.
module tb_vector_sequencer;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 16;
    localparam int LATENCY  = 2;
    localparam int AW       = 4;
    localparam int BW       = 16;

    logic clk = 1'b0;
    logic rst;
    logic [AW:0] num_vec;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic pass;
    logic [AW:0] err_count;
    logic [CHANNELS-1:0] err_lane_mask;
    logic [AW-1:0] first_err_idx;

    always #5 clk = ~clk;

    vector_sequencer_if #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) bus ();

    vector_sequencer #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS),
        .DEPTH(DEPTH), .LATENCY(LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .num_vec       (num_vec),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .err_lane_mask (err_lane_mask),
        .first_err_idx (first_err_idx)
    );

    // identity DUT: response is the stimulus two cycles later
    logic [BW-1:0] d1 = '0;
    logic [BW-1:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= bus.stim_data;
        d2 <= d1;
    end
    assign bus.dut_data = d2;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int pulses = 0;
    int last_v = 0;
    int done_seen = 0;
    logic [BW-1:0] stim_m [DEPTH];
    logic [BW-1:0] exp_m  [DEPTH];
    logic [BW-1:0] exp_q  [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [1:0] lanes_diff(input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
        logic [1:0] r;
        for (int l = 0; l < CHANNELS; l++)
            r[l] = a[l*DATA_W +: DATA_W] != b[l*DATA_W +: DATA_W];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // every issued vector must be the next one the model expects
    always @(negedge clk) begin
        if (rst && bus.stim_valid) begin
            pulses++;
            last_v = cyc;
            if (exp_q.size() == 0) check("stim_extra", 1, 0);
            else check("stim_data", bus.stim_data, exp_q.pop_front());
        end
        if (done) done_seen++;
    end

    task automatic load(input int a, input logic [BW-1:0] s,
                        input logic [BW-1:0] e);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(a);
        bus.load_stim = s;
        bus.load_exp  = e;
        @(negedge clk);
        bus.load_en = 1'b0;
        stim_m[a] = s;
        exp_m[a]  = e;
    endtask

    task automatic run(input string tag, input int num, input int abort_at);
        int n_iss, errs, first, start_cyc, n;
        logic [1:0] mask, d;
        bit ok_num, aborted, exp_pass;
        ok_num  = num >= 1 && num <= DEPTH;
        aborted = ok_num && abort_at >= 0 && abort_at < num;
        n_iss   = !ok_num ? 0 : (aborted ? abort_at + 1 : num);
        errs = 0; first = 0; mask = '0;
        for (int i = 0; i < n_iss; i++) begin
            d = lanes_diff(stim_m[i], exp_m[i]);
            if (d != 0) begin
                if (errs == 0) first = i;
                errs++;
                mask |= d;
            end
        end
        if (errs > DEPTH) errs = DEPTH;
        exp_pass = ok_num && !aborted && errs == 0;
        exp_q.delete();
        for (int i = 0; i < n_iss; i++) exp_q.push_back(stim_m[i]);
        pulses = 0;
        num_vec = (AW+1)'(num);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (abort_at >= 0) begin
            repeat (abort_at) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        if (n_iss > 0) check({tag, "_lat"}, cyc - last_v, LATENCY + 1);
        else check({tag, "_lat"}, cyc - start_cyc, 1);
        check({tag, "_pulses"}, pulses, n_iss);
        check({tag, "_errcnt"}, err_count, errs);
        check({tag, "_mask"}, err_lane_mask, mask);
        check({tag, "_first"}, first_err_idx, first);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_busy"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    function automatic logic [BW-1:0] sv(input int i);
        return {8'hA5, 8'(i * 17 + 3)};
    endfunction

    initial begin
        int ds0;
        rst = 1'b0;
        num_vec = '0;
        start = 1'b0;
        abort = 1'b0;
        bus.load_en = 1'b0;
        bus.load_addr = '0;
        bus.load_stim = '0;
        bus.load_exp = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.stim_valid, 0);
        check("rst_data", bus.stim_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_mask", err_lane_mask, 0);
        check("rst_first", first_err_idx, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) load(i, sv(i), sv(i));
        run("t1", 4, -1);
        check("t1_lit_pass", pass, 1);
        check("t1_lit_pulses", pulses, 4);

        load(2, sv(2), {8'h5A, sv(2) & 16'h00FF});
        run("t2", 4, -1);
        check("t2_lit_errcnt", err_count, 1);
        check("t2_lit_mask", err_lane_mask, 2'b10);
        check("t2_lit_first", first_err_idx, 2);
        check("t2_lit_pass", pass, 0);

        for (int i = 0; i < DEPTH; i++) load(i, sv(i), ~sv(i));
        run("t3", 16, -1);
        check("t3_lit_errcnt", err_count, 16);
        check("t3_lit_mask", err_lane_mask, 2'b11);

        for (int i = 0; i < DEPTH; i++) load(i, sv(i), sv(i));
        load(1, sv(1), sv(1) ^ 16'h0001);
        load(5, sv(5), sv(5) ^ 16'hFF00);
        run("t4", 8, 1);
        check("t4_lit_pulses", pulses, 2);
        check("t4_lit_errcnt", err_count, 1);
        check("t4_lit_mask", err_lane_mask, 2'b01);
        check("t4_lit_pass", pass, 0);

        run("t5a", 0, -1);
        check("t5_lit_pulses", pulses, 0);
        run("t5b", 17, -1);

        load(1, sv(1), sv(1));
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(stim_m[i]);
        num_vec = 5'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.load_en = 1'b1;
        bus.load_addr = '0;
        bus.load_stim = 16'hDEAD;
        bus.load_exp = 16'hBEEF;
        @(negedge clk);
        bus.load_en = 1'b0;
        check("t6_busy_run", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_valid", bus.stim_valid, 0);
        check("t6_data", bus.stim_data, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_errcnt", err_count, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        pulses = 0;
        ds0 = done_seen;
        repeat (20) @(negedge clk);
        check("t6_no_done", done_seen, ds0);
        check("t6_no_valid", pulses, 0);
        run("t6r", 4, -1);
        check("t6_lit_pass", pass, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
